// File: rtl/rst_seq.sv
// Purpose: sequences peripheral then core reset release after a qualified MMCM lock; handles sw/debug reset and lock loss.
// Latency: periph release LOCK_FILTER+PERIPH_DELAY edges after synchronized lock rises, core a further CORE_DELAY edges.
// Backpressure: none; sw_rst_req_i is sampled only in RUN and acknowledged with a single-cycle sw_rst_ack_o.
module rst_seq #(
    parameter int LOCK_FILTER  = 8,
    parameter int PERIPH_DELAY = 16,
    parameter int CORE_DELAY   = 16,
    parameter int SW_HOLD      = 32
) (
    input  logic       clk_sys,
    input  logic       rst_sys_n,
    input  logic       locked_i,
    input  logic       sw_rst_req_i,
    output logic       sw_rst_ack_o,
    output logic       rst_periph_n_o,
    output logic       rst_core_n_o,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt_o
);

    // State encodings are exported on state_o, so they are fixed values.
    localparam logic [2:0] ST_RESET      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_DLY_PERIPH = 3'd2;
    localparam logic [2:0] ST_DLY_CORE   = 3'd3;
    localparam logic [2:0] ST_RUN        = 3'd4;
    localparam logic [2:0] ST_SW_RST     = 3'd5;

    // One counter is shared by every timed state, so it is sized for the longest interval.
    localparam int MAX_AB  = (LOCK_FILTER  > PERIPH_DELAY) ? LOCK_FILTER  : PERIPH_DELAY;
    localparam int MAX_CD  = (CORE_DELAY   > SW_HOLD)      ? CORE_DELAY   : SW_HOLD;
    localparam int MAX_ALL = (MAX_AB       > MAX_CD)       ? MAX_AB       : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    // Terminal counts: the transition fires on the last cycle of each interval.
    localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SW_HOLD - 1);

    logic             locked_m_q;
    logic             locked_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             periph_n_q;
    logic             core_n_q;
    logic [7:0]       loss_cnt_q;
    logic             loss_d;
    logic             lock_lost;

    assign lock_lost = ~locked_s_q;

    // Two-flop lock synchronizer; held clear during the RESET cycle so qualification
    // always starts from observations taken after the block has left reset.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            locked_m_q <= 1'b0;
            locked_s_q <= 1'b0;
        end else if (state_q == ST_RESET) begin
            locked_m_q <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            locked_m_q <= locked_i;
            locked_s_q <= locked_m_q;
        end
    end

    // Next-state, shared counter and ack decode; lock loss outranks every other exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ack_d   = 1'b0;
        loss_d  = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!locked_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LF_LAST) begin
                    state_d = ST_DLY_PERIPH;
                end
            end
            ST_DLY_PERIPH: begin
                if (lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = 1'b1;
                end else if (cnt_q == PD_LAST) begin
                    state_d = ST_DLY_CORE;
                end
            end
            ST_DLY_CORE: begin
                if (lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = 1'b1;
                end else if (cnt_q == CD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_d = ST_SW_RST;
                    ack_d   = 1'b1;
                end
            end
            ST_SW_RST: begin
                if (lock_lost) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = 1'b1;
                end else if (cnt_q == SW_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        // Every state starts its interval from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counter and reset outputs all register on the same edge so they never disagree.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            periph_n_q <= 1'b0;
            core_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            periph_n_q <= (state_d == ST_DLY_CORE) || (state_d == ST_RUN);
            core_n_q   <= (state_d == ST_RUN);
        end
    end

    // Saturating lock-loss event counter.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign state_o         = state_q;
    assign sw_rst_ack_o    = ack_q;
    assign rst_periph_n_o  = periph_n_q;
    assign rst_core_n_o    = core_n_q;
    assign lock_loss_cnt_o = loss_cnt_q;

endmodule
